// File: rtl/onehot_enc_pkg.sv
// Shared types and elaboration helpers for the one-hot scan encoder.
package onehot_enc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/onehot_scan_encoder_if.sv
// Handshake bundle: flag vector in, serial index stream out.
interface onehot_scan_encoder_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_vec;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             drop_zero;

    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_idx, out_last, drop_zero
    );

    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_idx, out_last, drop_zero
    );
endinterface

// File: rtl/lsb_priority_enc.sv
// Combinational lowest-set-bit encoder with single-bit detect and bit clear.
module lsb_priority_enc #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             single,
    output logic [WIDTH-1:0] cleared
);
    logic found;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (!found && vec[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

    assign cleared = vec & (vec - WIDTH'(1));
    assign any     = |vec;
    assign single  = any && (cleared == '0);

endmodule

// File: rtl/onehot_scan_encoder.sv
// Serialises every set bit of an accepted flag vector into ascending binary
// indices, one beat per handshake, marking the final beat with out_last.
module onehot_scan_encoder
    import onehot_enc_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    onehot_scan_encoder_if.slave  bus
);

    if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
        $error("onehot_scan_encoder: WIDTH must be in 2..64");
    end
    if (IDX_W != clog2(WIDTH)) begin : g_bad_idx_w
        $error("onehot_scan_encoder: IDX_W must equal clog2(WIDTH)");
    end

    state_e           state_q,     state_d;
    logic [WIDTH-1:0] pending_q,   pending_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] out_idx_q,   out_idx_d;
    logic             out_last_q,  out_last_d;
    logic             drop_zero_q, drop_zero_d;

    logic [WIDTH-1:0] enc_in;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    logic             enc_single;
    logic [WIDTH-1:0] enc_cleared;

    // pending holds the bits still to emit *after* the beat on the outputs,
    // so one encoder serves both acceptance and each subsequent beat.
    assign enc_in = (state_q == IDLE) ? bus.in_vec : pending_q;

    lsb_priority_enc #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_enc (
        .vec     (enc_in),
        .idx     (enc_idx),
        .any     (enc_any),
        .single  (enc_single),
        .cleared (enc_cleared)
    );

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        drop_zero_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (enc_any) begin
                        state_d     = EMIT;
                        pending_d   = enc_cleared;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                        out_idx_d   = enc_idx;
                        out_last_d  = enc_single;
                    end else begin
                        drop_zero_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    if (out_last_q) begin
                        state_d     = IDLE;
                        pending_d   = '0;
                        in_ready_d  = 1'b1;
                        out_valid_d = 1'b0;
                        out_idx_d   = '0;
                        out_last_d  = 1'b0;
                    end else begin
                        pending_d   = enc_cleared;
                        out_idx_d   = enc_idx;
                        out_last_d  = enc_single;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            drop_zero_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            drop_zero_q <= drop_zero_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;
    assign bus.drop_zero = drop_zero_q;

endmodule

// File: tb/tb_onehot_scan_encoder.sv
// Directed bench for onehot_scan_encoder at WIDTH=8 and WIDTH=5.
module tb_onehot_scan_encoder;

    logic clk;
    logic rst_n;
    int unsigned n_tests;
    int unsigned n_fail;
    int unsigned hs_count;

    onehot_scan_encoder_if #(.WIDTH(8), .IDX_W(3)) bus_a ();
    onehot_scan_encoder_if #(.WIDTH(5), .IDX_W(3)) bus_b ();

    onehot_scan_encoder #(.WIDTH(8), .IDX_W(3)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    onehot_scan_encoder #(.WIDTH(5), .IDX_W(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && bus_a.out_valid && bus_a.out_ready) hs_count <= hs_count + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        hs_count = 0;
        rst_n = 1'b0;
        bus_a.in_valid = 1'b0; bus_a.in_vec = '0; bus_a.out_ready = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_vec = '0; bus_b.out_ready = 1'b0;
        tick(); tick();
        chk("rst_in_ready",  32'(bus_a.in_ready),  1);
        chk("rst_out_valid", 32'(bus_a.out_valid), 0);
        chk("rst_out_idx",   32'(bus_a.out_idx),   0);
        chk("rst_out_last",  32'(bus_a.out_last),  0);
        chk("rst_drop_zero", 32'(bus_a.drop_zero), 0);
        rst_n = 1'b1;

        // 1010_0100 -> 2, 5, 7(last)
        bus_a.in_valid = 1'b1; bus_a.in_vec = 8'b1010_0100; bus_a.out_ready = 1'b1;
        tick();
        bus_a.in_valid = 1'b0;
        chk("a4_b0_valid", 32'(bus_a.out_valid), 1);
        chk("a4_b0_idx",   32'(bus_a.out_idx),   2);
        chk("a4_b0_last",  32'(bus_a.out_last),  0);
        chk("a4_b0_ready", 32'(bus_a.in_ready),  0);
        tick();
        chk("a4_b1_idx",   32'(bus_a.out_idx),   5);
        chk("a4_b1_last",  32'(bus_a.out_last),  0);
        tick();
        chk("a4_b2_idx",   32'(bus_a.out_idx),   7);
        chk("a4_b2_last",  32'(bus_a.out_last),  1);
        chk("a4_b2_valid", 32'(bus_a.out_valid), 1);
        tick();
        chk("a4_end_valid", 32'(bus_a.out_valid), 0);
        chk("a4_end_ready", 32'(bus_a.in_ready),  1);
        chk("a4_end_idx",   32'(bus_a.out_idx),   0);

        // all-zero vector is dropped
        bus_a.in_valid = 1'b1; bus_a.in_vec = 8'h00;
        tick();
        bus_a.in_valid = 1'b0;
        chk("zero_drop",  32'(bus_a.drop_zero), 1);
        chk("zero_valid", 32'(bus_a.out_valid), 0);
        chk("zero_ready", 32'(bus_a.in_ready),  1);
        tick();
        chk("zero_drop_clr", 32'(bus_a.drop_zero), 0);
        chk("zero_valid2",   32'(bus_a.out_valid), 0);

        // all-ones with alternating stalls; in_vec wiggles during EMIT
        hs_count = 0;
        bus_a.in_valid = 1'b1; bus_a.in_vec = 8'hFF; bus_a.out_ready = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) begin
            bus_a.in_vec = 8'h0F;
            bus_a.out_ready = 1'b0;
            tick();
            chk("ff_stall_valid", 32'(bus_a.out_valid), 1);
            chk("ff_stall_idx",   32'(bus_a.out_idx),   32'(k));
            chk("ff_stall_last",  32'(bus_a.out_last),  32'(k == 7));
            chk("ff_stall_ready", 32'(bus_a.in_ready),  0);
            bus_a.out_ready = 1'b1;
            tick();
            if (k < 7) begin
                chk("ff_next_idx", 32'(bus_a.out_idx), 32'(k + 1));
            end else begin
                chk("ff_done_valid", 32'(bus_a.out_valid), 0);
            end
        end
        bus_a.in_valid = 1'b0;
        chk("ff_handshakes", hs_count, 8);
        chk("ff_done_ready", 32'(bus_a.in_ready), 1);

        // top bit alone, then bit 0 accepted right after
        bus_a.in_valid = 1'b1; bus_a.in_vec = 8'b1000_0000; bus_a.out_ready = 1'b1;
        tick();
        chk("b7_idx",   32'(bus_a.out_idx),   7);
        chk("b7_last",  32'(bus_a.out_last),  1);
        chk("b7_valid", 32'(bus_a.out_valid), 1);
        bus_a.in_vec = 8'b0000_0001;
        tick();
        chk("b7_gap_valid", 32'(bus_a.out_valid), 0);
        chk("b7_gap_ready", 32'(bus_a.in_ready),  1);
        tick();
        bus_a.in_valid = 1'b0;
        chk("b0_idx",   32'(bus_a.out_idx),   0);
        chk("b0_last",  32'(bus_a.out_last),  1);
        chk("b0_valid", 32'(bus_a.out_valid), 1);
        tick();
        chk("b0_end_valid", 32'(bus_a.out_valid), 0);

        // reset in the middle of 0110_0000
        bus_a.in_valid = 1'b1; bus_a.in_vec = 8'b0110_0000; bus_a.out_ready = 1'b1;
        tick();
        bus_a.in_valid = 1'b0;
        chk("r_b0_idx", 32'(bus_a.out_idx), 5);
        tick();
        chk("r_b1_idx", 32'(bus_a.out_idx), 6);
        bus_a.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_async_valid", 32'(bus_a.out_valid), 0);
        chk("r_async_idx",   32'(bus_a.out_idx),   0);
        chk("r_async_ready", 32'(bus_a.in_ready),  1);
        tick();
        rst_n = 1'b1;
        bus_a.out_ready = 1'b1;
        tick();
        chk("r_after_valid", 32'(bus_a.out_valid), 0);
        chk("r_after_ready", 32'(bus_a.in_ready),  1);
        tick();
        chk("r_after_valid2", 32'(bus_a.out_valid), 0);

        // WIDTH=5 instance: 10001 -> 0, 4(last)
        bus_b.in_valid = 1'b1; bus_b.in_vec = 5'b10001; bus_b.out_ready = 1'b1;
        tick();
        bus_b.in_valid = 1'b0;
        chk("w5_b0_idx",  32'(bus_b.out_idx),  0);
        chk("w5_b0_last", 32'(bus_b.out_last), 0);
        tick();
        chk("w5_b1_idx",  32'(bus_b.out_idx),  4);
        chk("w5_b1_last", 32'(bus_b.out_last), 1);
        tick();
        chk("w5_end_valid", 32'(bus_b.out_valid), 0);
        chk("w5_end_ready", 32'(bus_b.in_ready),  1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/onehot_scan_encoder.md
Name: onehot_scan_encoder

Overview:
- Inverse of the select-to-one-hot decoders in the decoder library.
- Accepts a WIDTH-bit request/flag vector over a valid/ready handshake.
- Emits the binary index of every set bit, one per output beat, ascending order, tagging the final beat with out_last.
- Sits between flag-producing logic (decoder outputs, interrupt/request lines) and consumers that need a serial stream of binary indices.

Parameters:
WIDTH, 8, number of input flag bits; legal range 2..64.
IDX_W, 3, width of out_idx; must equal ceil(log2(WIDTH)); elaboration error otherwise.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  in_vec is presented.
in_ready  output  1  block can accept a vector.
in_vec  input  WIDTH  flag vector; sampled only on in_valid && in_ready.
out_valid  output  1  out_idx/out_last hold a valid beat.
out_ready  input  1  consumer accepts the beat.
out_idx  output  IDX_W  binary index of the current lowest pending set bit.
out_last  output  1  current beat is the final set bit of the vector.
drop_zero  output  1  one-cycle pulse: an all-zero vector was accepted and discarded.

Behaviour:
- Reset (async assert, sync release) forces:
  - state=IDLE, pending register=0.
  - in_ready=1, out_valid=0, out_idx=0, out_last=0, drop_zero=0.
- States: IDLE, EMIT.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_vec!=0: pending<=in_vec, go to EMIT.
  - On in_valid && in_vec==0: stay in IDLE, drop_zero=1 on the next cycle only.
- EMIT:
  - in_ready=0, out_valid=1.
  - out_idx = index of the lowest set bit of pending.
  - out_last = (pending has exactly one bit set).
- Beat handshake (out_valid && out_ready): clear the lowest set bit of pending.
  - If out_last: next state IDLE, in_ready=1 the following cycle.
  - Otherwise: stay in EMIT; the next index appears the following cycle.
- Stall (out_ready=0): out_idx and out_last held stable, no bits cleared.
- Latency:
  - First beat is valid the cycle after input acceptance.
  - Throughput is one index per cycle under continuous out_ready.
  - A vector with N set bits occupies N cycles in EMIT (minimum).
- No overlap: the next vector is accepted no earlier than the cycle after the last beat handshake. Back-to-back vectors therefore have one idle cycle between them.
- in_vec changes while in EMIT are ignored.
- All-ones vector: emits 0..WIDTH-1, out_last on index WIDTH-1.
- Single-bit vector at bit WIDTH-1: exactly one beat, out_idx=WIDTH-1, out_last=1.
- rst_n asserted mid-EMIT:
  - Outputs return to reset values immediately (asynchronous).
  - Pending bits are discarded, no partial beat is retained.
- out_idx is only meaningful while out_valid=1; it is driven 0 in IDLE.
- drop_zero never coincides with out_valid=1.

Decomposition:
- Shared package onehot_enc_pkg:
  - state enum (IDLE, EMIT).
  - clog2 constant function used to check IDX_W.
- One sub-module: lsb_priority_enc (combinational).
  - Inputs: vector.
  - Outputs: index of the lowest set bit, any-set flag, single-bit flag, vector with the lowest bit cleared.
  - The top level holds only the FSM, the pending register and the handshake logic.

Test Plan:
- Reset then in_vec=8'b1010_0100, out_ready=1 -> beats idx 2,5,7 on consecutive cycles; out_last only on 7; in_ready returns to 1 the cycle after.
- in_vec=8'b0000_0000 accepted -> no out_valid; drop_zero high exactly one cycle; in_ready stays 1.
- in_vec=8'b1111_1111, out_ready toggled 1,0,1,0... -> idx 0..7 in order, each held stable through stalls, out_last on 7 only; 8 handshakes total.
- in_vec=8'b1000_0000 -> single beat idx=7, out_last=1; then immediate new in_vec=8'b0000_0001 accepted next cycle -> idx=0, out_last=1.
- in_vec=8'b0110_0000, rst_n pulsed low after the first beat (idx 5) -> out_valid drops asynchronously; after release in_ready=1 and no idx 6 beat appears.
- WIDTH=5, IDX_W=3, in_vec=5'b10001 -> idx 0 then 4 with out_last; IDX_W=2 with WIDTH=5 fails elaboration.
